// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared types and constants for the Ethernet TX packet arbiter
//
// Purpose: state encoding, arbitration mode constants and the saturating
// starvation-counter helper used by eth_tx_pkt_arbiter and eth_arb_grant.
// Ports: none (package).

package eth_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2
  } arb_state_t;

  localparam int ARB_RR   = 0;
  localparam int ARB_PRIO = 1;

  // STARVE_LIMIT tops out at 255, so 8 bits always hold the guard count.
  localparam int STARVE_W = 8;

  // Counter stops at the limit; the grant logic only ever compares for equality.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/eth_arb_grant.sv
// rtl/eth_arb_grant.sv - combinational 2-port packet grant decision
//
// Purpose: picks the winning port when the arbiter leaves IDLE.
// Ports:
//   valid[1:0]   per-port tvalid (bit n = port n)
//   active_port  port granted last time
//   starve_cnt   consecutive port-1 grants while port 0 waited
//   grant        winning port (0 or 1); only meaningful when valid != 0

module eth_arb_grant
  import eth_arb_pkg::*;
#(
  parameter int MODE         = ARB_RR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic [1:0]          valid,
  input  logic                active_port,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant
);

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b10) begin
      grant = 1'b1;
    end else if (valid == 2'b11) begin
      if (MODE == ARB_PRIO) begin
        // Port 1 wins until port 0 has been passed over STARVE_LIMIT times.
        grant = (starve_cnt != STARVE_W'(STARVE_LIMIT));
      end else begin
        grant = ~active_port;
      end
    end
  end

endmodule

// File: rtl/eth_tx_pkt_arbiter.sv
// rtl/eth_tx_pkt_arbiter.sv - packet-granular 2:1 arbiter for the Ethernet IPv4 egress path
//
// Purpose: shares the TX framer between the host DMA stream (port 0) and the
// RFNoC CHDR stream (port 1) without interleaving packets.
// Ports:
//   bus_clk, bus_rst          clock, synchronous active-high reset
//   enable                    arbitration enable, sampled only in IDLE
//   in0_*, in1_*              source streams (tdata/tkeep/tlast/tvalid/tready)
//   out_*                     arbitrated stream to the framer
//   busy                      packet in progress
//   active_port               port last granted
//   pkt_cnt0, pkt_cnt1        wrapping completed-packet counters

module eth_tx_pkt_arbiter
  import eth_arb_pkg::*;
#(
  parameter int DWIDTH       = 64,
  parameter int MODE         = ARB_RR,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic                bus_clk,
  input  logic                bus_rst,
  input  logic                enable,
  input  logic [DWIDTH-1:0]   in0_tdata,
  input  logic [DWIDTH/8-1:0] in0_tkeep,
  input  logic                in0_tlast,
  input  logic                in0_tvalid,
  output logic                in0_tready,
  input  logic [DWIDTH-1:0]   in1_tdata,
  input  logic [DWIDTH/8-1:0] in1_tkeep,
  input  logic                in1_tlast,
  input  logic                in1_tvalid,
  output logic                in1_tready,
  output logic [DWIDTH-1:0]   out_tdata,
  output logic [DWIDTH/8-1:0] out_tkeep,
  output logic                out_tlast,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                busy,
  output logic                active_port,
  output logic [CNT_W-1:0]    pkt_cnt0,
  output logic [CNT_W-1:0]    pkt_cnt1
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_active_port;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0]    r_pkt_cnt0;
  logic [CNT_W-1:0]    r_pkt_cnt1;
  logic                w_req;
  logic                w_grant;
  logic                w_eop;

  assign w_req = enable & (in0_tvalid | in1_tvalid);

  eth_arb_grant #(
    .MODE         (MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .valid       ({in1_tvalid, in0_tvalid}),
    .active_port (r_active_port),
    .starve_cnt  (r_starve_cnt),
    .grant       (w_grant)
  );

  // Passthrough is purely combinational so a granted packet adds no per-beat latency.
  always_comb begin
    w_state_nxt = r_state;
    out_tdata   = '0;
    out_tkeep   = '0;
    out_tlast   = 1'b0;
    out_tvalid  = 1'b0;
    in0_tready  = 1'b0;
    in1_tready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = w_grant ? ST_PASS1 : ST_PASS0;
        end
      end
      ST_PASS0: begin
        out_tdata  = in0_tdata;
        out_tkeep  = in0_tkeep;
        out_tlast  = in0_tlast;
        out_tvalid = in0_tvalid;
        in0_tready = out_tready;
        if (in0_tvalid && out_tready && in0_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PASS1: begin
        out_tdata  = in1_tdata;
        out_tkeep  = in1_tkeep;
        out_tlast  = in1_tlast;
        out_tvalid = in1_tvalid;
        in1_tready = out_tready;
        if (in1_tvalid && out_tready && in1_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_eop = out_tvalid & out_tready & out_tlast;

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      r_state       <= ST_IDLE;
      r_active_port <= 1'b1;
      r_starve_cnt  <= '0;
      r_pkt_cnt0    <= '0;
      r_pkt_cnt1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_req) begin
        r_active_port <= w_grant;
        if (w_grant) begin
          // Only a port-1 win that actually bypassed a waiting port 0 counts.
          if (in0_tvalid) begin
            r_starve_cnt <= sat_inc(r_starve_cnt, STARVE_W'(STARVE_LIMIT));
          end
        end else begin
          r_starve_cnt <= '0;
        end
      end
      if (w_eop) begin
        if (r_state == ST_PASS0) begin
          r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
        end else begin
          r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign active_port = r_active_port;
  assign pkt_cnt0    = r_pkt_cnt0;
  assign pkt_cnt1    = r_pkt_cnt1;

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// tb/tb_eth_tx_pkt_arbiter.sv - scoreboard bench for eth_tx_pkt_arbiter
`timescale 1ns/1ps

module tb_eth_tx_pkt_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic bus_clk = 1'b0;
  logic bus_rst = 1'b1;
  always #5 bus_clk = ~bus_clk;

  // Round-robin instance
  logic          enable;
  logic [DW-1:0] in0_tdata, in1_tdata, out_tdata;
  logic [KW-1:0] in0_tkeep, in1_tkeep, out_tkeep;
  logic          in0_tlast, in0_tvalid, in0_tready;
  logic          in1_tlast, in1_tvalid, in1_tready;
  logic          out_tlast, out_tvalid, out_tready;
  logic          busy, active_port;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  // Priority instance (STARVE_LIMIT = 2)
  logic          p_enable;
  logic [DW-1:0] p_in0_tdata, p_in1_tdata, p_out_tdata;
  logic [KW-1:0] p_in0_tkeep, p_in1_tkeep, p_out_tkeep;
  logic          p_in0_tlast, p_in0_tvalid, p_in0_tready;
  logic          p_in1_tlast, p_in1_tvalid, p_in1_tready;
  logic          p_out_tlast, p_out_tvalid, p_out_tready;
  logic          p_busy, p_active_port;
  logic [CW-1:0] p_pkt_cnt0, p_pkt_cnt1;

  eth_tx_pkt_arbiter #(.DWIDTH(DW), .MODE(0), .STARVE_LIMIT(4), .CNT_W(CW)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst), .enable(enable),
    .in0_tdata(in0_tdata), .in0_tkeep(in0_tkeep), .in0_tlast(in0_tlast),
    .in0_tvalid(in0_tvalid), .in0_tready(in0_tready),
    .in1_tdata(in1_tdata), .in1_tkeep(in1_tkeep), .in1_tlast(in1_tlast),
    .in1_tvalid(in1_tvalid), .in1_tready(in1_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .busy(busy), .active_port(active_port), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  eth_tx_pkt_arbiter #(.DWIDTH(DW), .MODE(1), .STARVE_LIMIT(2), .CNT_W(CW)) dut_prio (
    .bus_clk(bus_clk), .bus_rst(bus_rst), .enable(p_enable),
    .in0_tdata(p_in0_tdata), .in0_tkeep(p_in0_tkeep), .in0_tlast(p_in0_tlast),
    .in0_tvalid(p_in0_tvalid), .in0_tready(p_in0_tready),
    .in1_tdata(p_in1_tdata), .in1_tkeep(p_in1_tkeep), .in1_tlast(p_in1_tlast),
    .in1_tvalid(p_in1_tvalid), .in1_tready(p_in1_tready),
    .out_tdata(p_out_tdata), .out_tkeep(p_out_tkeep), .out_tlast(p_out_tlast),
    .out_tvalid(p_out_tvalid), .out_tready(p_out_tready),
    .busy(p_busy), .active_port(p_active_port), .pkt_cnt0(p_pkt_cnt0), .pkt_cnt1(p_pkt_cnt1)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    first_hs = -1;
  int    last_hs = -1;
  int    p_hs_cnt = 0;
  beat_t exp_q[$];
  beat_t expp_q[$];

  always @(posedge bus_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int p, input int tag, input int b);
    return {8'(p), 24'(tag), 32'(b)};
  endfunction

  // Port 0 marks its final beat with a partial keep so the keep mux is exercised.
  function automatic logic [KW-1:0] kf(input int p, input int b, input int n);
    return (p == 0 && b == n - 1) ? 8'h0F : 8'hFF;
  endfunction

  task automatic push_pkt(input int p, input int tag, input int n);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.data = mk(p, tag, b);
      e.keep = kf(p, b, n);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input int p, input int tag, input int n);
    bit hs;
    int w;
    for (int b = 0; b < n; b++) begin
      hs = 1'b0;
      w  = 0;
      if (p == 0) begin
        in0_tdata = mk(p, tag, b); in0_tkeep = kf(p, b, n);
        in0_tlast = (b == n - 1);  in0_tvalid = 1'b1;
      end else begin
        in1_tdata = mk(p, tag, b); in1_tkeep = kf(p, b, n);
        in1_tlast = (b == n - 1);  in1_tvalid = 1'b1;
      end
      while (!hs && w < 300) begin
        @(negedge bus_clk);
        hs = (p == 0) ? (in0_tvalid & in0_tready) : (in1_tvalid & in1_tready);
        @(posedge bus_clk); #1;
        w++;
      end
      if (!hs) begin
        n_cmp++; n_bad++;
        $display("FAIL drive_timeout: port %0d tag %0d beat %0d got no handshake, required one", p, tag, b);
      end
    end
    if (p == 0) in0_tvalid = 1'b0; else in1_tvalid = 1'b0;
  endtask

  task automatic wait_sb_empty();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || expp_q.size() != 0) && w < 500) begin
      @(posedge bus_clk); #1;
      w++;
    end
    chk("sb_drained", 64'(exp_q.size() + expp_q.size()), 64'd0);
  endtask

  // Round-robin instance monitor
  always @(negedge bus_clk) begin
    beat_t e;
    if (!bus_rst && out_tvalid && out_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: got beat %0h, required no beat", out_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_tdata, e.data);
        chk("sb_keep", 64'(out_tkeep), 64'(e.keep));
        chk("sb_last", 64'(out_tlast), 64'(e.last));
      end
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
  end

  // Priority instance monitor: data identifies the granted port
  always @(negedge bus_clk) begin
    beat_t e;
    if (!bus_rst && p_out_tvalid && p_out_tready) begin
      if (expp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL prio_unexpected: got beat %0h, required no beat", p_out_tdata);
      end else begin
        e = expp_q.pop_front();
        chk("prio_grant_seq", p_out_tdata, e.data);
      end
      p_hs_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic          bp_done;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          d1_done;
  int            base;
  int            w;
  logic [CW-1:0] cnt_before;
  bit            hs;
  beat_t         eb;

  initial begin
    enable = 1'b1; out_tready = 1'b1;
    in0_tdata = '0; in0_tkeep = '0; in0_tlast = 1'b0; in0_tvalid = 1'b0;
    in1_tdata = '0; in1_tkeep = '0; in1_tlast = 1'b0; in1_tvalid = 1'b0;
    p_enable = 1'b0; p_out_tready = 1'b1;
    p_in0_tdata = 64'hA0; p_in0_tkeep = 8'hFF; p_in0_tlast = 1'b1; p_in0_tvalid = 1'b1;
    p_in1_tdata = 64'hB1; p_in1_tkeep = 8'hFF; p_in1_tlast = 1'b1; p_in1_tvalid = 1'b1;

    // Reset values
    repeat (3) @(posedge bus_clk);
    @(negedge bus_clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_active_port", 64'(active_port), 64'd1);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_in0_tready", 64'(in0_tready), 64'd0);
    chk("rst_in1_tready", 64'(in1_tready), 64'd0);
    chk("rst_pkt_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst_pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    @(posedge bus_clk); #1;
    bus_rst = 1'b0;

    // Round robin: both ports stream 3-beat packets, expected order 0,1,0,1...
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, k, 3);
      push_pkt(1, k, 3);
    end
    hs_cnt = 0; first_hs = -1;
    fork
      begin for (int k = 0; k < 4; k++) drive(0, k, 3); end
      begin for (int k = 0; k < 4; k++) drive(1, k, 3); end
    join
    wait_sb_empty();
    chk("rr_pkt_cnt0", 64'(pkt_cnt0), 64'd4);
    chk("rr_pkt_cnt1", 64'(pkt_cnt1), 64'd4);
    chk("rr_beats", 64'(hs_cnt), 64'd24);
    chk("rr_span_cycles", 64'(last_hs - first_hs), 64'd30);

    // Starvation guard on the priority instance: grants 1,1,0,1,1,0
    begin
      int seq[6];
      seq = '{1, 1, 0, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
        eb.data = (seq[i] == 1) ? 64'hB1 : 64'hA0;
        eb.keep = 8'hFF;
        eb.last = 1'b1;
        expp_q.push_back(eb);
      end
    end
    @(posedge bus_clk); #1;
    p_enable = 1'b1;
    w = 0;
    while (p_hs_cnt < 6 && w < 100) begin
      @(posedge bus_clk); #1;
      w++;
    end
    p_enable = 1'b0;
    repeat (4) @(posedge bus_clk);
    #1;
    chk("prio_beats", 64'(p_hs_cnt), 64'd6);
    chk("prio_pkt_cnt0", 64'(p_pkt_cnt0), 64'd2);
    chk("prio_pkt_cnt1", 64'(p_pkt_cnt1), 64'd4);

    // Backpressure: 4-beat port-0 packet with out_tready toggling
    push_pkt(0, 50, 4);
    cnt_before = pkt_cnt0;
    bp_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    fork
      begin drive(0, 50, 4); bp_done = 1'b1; end
      begin
        while (!bp_done) begin
          @(posedge bus_clk); #1;
          if (!bp_done) out_tready = ~out_tready;
        end
      end
      begin
        while (!bp_done) begin
          @(negedge bus_clk);
          chk("bp_in1_tready", 64'(in1_tready), 64'd0);
          if (prev_stall) chk("bp_data_held", out_tdata, prev_data);
          prev_stall = out_tvalid & ~out_tready;
          prev_data  = out_tdata;
        end
      end
    join
    out_tready = 1'b1;
    wait_sb_empty();
    chk("bp_pkt_cnt0", 64'(pkt_cnt0), 64'(CW'(cnt_before + 1'b1)));

    // Enable drop mid-packet
    push_pkt(0, 60, 5);
    push_pkt(1, 61, 2);
    base = hs_cnt;
    fork
      drive(0, 60, 5);
      begin
        w = 0;
        while (hs_cnt < base + 1 && w < 100) begin
          @(posedge bus_clk); #1;
          w++;
        end
        enable = 1'b0;
      end
    join
    chk("en_drop_beats", 64'(hs_cnt - base), 64'd5);
    d1_done = 1'b0;
    fork
      begin drive(1, 61, 2); d1_done = 1'b1; end
    join_none
    for (int i = 0; i < 4; i++) begin
      @(negedge bus_clk);
      chk("en_hold_busy", 64'(busy), 64'd0);
      chk("en_hold_in0_tready", 64'(in0_tready), 64'd0);
      chk("en_hold_in1_tready", 64'(in1_tready), 64'd0);
      chk("en_hold_in1_tvalid", 64'(in1_tvalid), 64'd1);
    end
    @(posedge bus_clk); #1;
    enable = 1'b1;
    @(negedge bus_clk);
    chk("reen_same_cycle_busy", 64'(busy), 64'd0);
    @(negedge bus_clk);
    chk("reen_busy", 64'(busy), 64'd1);
    chk("reen_active_port", 64'(active_port), 64'd1);
    w = 0;
    while (!d1_done && w < 200) begin
      @(posedge bus_clk); #1;
      w++;
    end
    chk("reen_done", 64'(d1_done), 64'd1);
    wait_sb_empty();

    // Reset mid-packet on port 1: beats 0 and 1 pass, reset lands on beat 2
    for (int b = 0; b < 2; b++) begin
      eb.data = mk(1, 70, b); eb.keep = 8'hFF; eb.last = 1'b0;
      exp_q.push_back(eb);
    end
    for (int b = 0; b < 2; b++) begin
      in1_tdata = mk(1, 70, b); in1_tkeep = 8'hFF; in1_tlast = 1'b0; in1_tvalid = 1'b1;
      hs = 1'b0; w = 0;
      while (!hs && w < 100) begin
        @(negedge bus_clk);
        hs = in1_tvalid & in1_tready;
        @(posedge bus_clk); #1;
        w++;
      end
    end
    in1_tdata = mk(1, 70, 2);
    bus_rst = 1'b1;
    @(posedge bus_clk);
    @(negedge bus_clk);
    chk("mrst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_pkt_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("mrst_pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    in1_tvalid = 1'b0;
    @(posedge bus_clk); #1;
    bus_rst = 1'b0;
    push_pkt(0, 80, 1);
    push_pkt(1, 81, 1);
    fork
      drive(0, 80, 1);
      drive(1, 81, 1);
      begin
        @(negedge bus_clk);
        @(negedge bus_clk);
        chk("post_rst_busy", 64'(busy), 64'd1);
        chk("post_rst_grant", 64'(active_port), 64'd0);
      end
    join
    wait_sb_empty();

    // Counter wrap: 17 single-beat port-0 packets into a 4-bit counter
    bus_rst = 1'b1;
    repeat (2) @(posedge bus_clk);
    #1;
    bus_rst = 1'b0;
    hs_cnt = 0; first_hs = -1;
    for (int k = 0; k < 17; k++) begin
      push_pkt(0, 100 + k, 1);
      drive(0, 100 + k, 1);
    end
    wait_sb_empty();
    chk("wrap_pkt_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("wrap_pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("wrap_beats", 64'(hs_cnt), 64'd17);
    chk("wrap_span_cycles", 64'(last_hs - first_hs), 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
